// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of core, host and memory signals shared by the rv32i memory arbiter.
// The arbiter takes the slave view; the core/host/memory side takes the master view.
interface rv32i_mem_arbiter_if;
    logic        run;
    logic        core_ena;
    logic [31:0] core_mem_addr;
    logic [31:0] core_mem_wr_data;
    logic        core_mem_wr_ena;
    logic [31:0] core_mem_rd_data;
    logic        host_req;
    logic [31:0] host_addr;
    logic [31:0] host_wr_data;
    logic        host_wr_ena;
    logic        host_gnt;
    logic [31:0] host_rd_data;
    logic        host_rd_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    modport slave (
        input  run, core_mem_addr, core_mem_wr_data, core_mem_wr_ena,
        input  host_req, host_addr, host_wr_data, host_wr_ena, mem_rd_data,
        output core_ena, core_mem_rd_data, host_gnt, host_rd_data, host_rd_valid,
        output mem_addr, mem_wr_data, mem_wr_ena
    );

    modport master (
        output run, core_mem_addr, core_mem_wr_data, core_mem_wr_ena,
        output host_req, host_addr, host_wr_data, host_wr_ena, mem_rd_data,
        input  core_ena, core_mem_rd_data, host_gnt, host_rd_data, host_rd_valid,
        input  mem_addr, mem_wr_data, mem_wr_ena
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between the rv32i core and a host, with a core min slot and bounded host bursts.
// Define ARB_STALL_STATS_EN to add the stall_cycles counter output.
module rv32i_mem_arbiter #(
    parameter int CORE_MIN_SLOT  = 4,
    parameter int HOST_MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_mem_arbiter_if.slave  bus
`ifdef ARB_STALL_STATS_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int SW = (CORE_MIN_SLOT > 0) ? $clog2(CORE_MIN_SLOT + 1) : 1;
    localparam int BW = $clog2(HOST_MAX_BURST + 1);
    localparam logic [SW-1:0] SLOT_MAX  = SW'(CORE_MIN_SLOT);
    localparam logic [BW-1:0] BURST_MAX = BW'(HOST_MAX_BURST);

    // S_CORE: core owns memory | S_HANDOVER: 1-cycle turnaround | S_HOST: host owns memory
    typedef enum logic [1:0] {S_CORE, S_HANDOVER, S_HOST} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] slot_cnt, slot_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          rd_grant;

    assign bus.core_mem_rd_data = bus.mem_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_CORE;
            slot_cnt          <= '0;
            burst_cnt         <= '0;
            bus.host_rd_data  <= '0;
            bus.host_rd_valid <= 1'b0;
        end else begin
            state             <= state_nxt;
            slot_cnt          <= slot_nxt;
            burst_cnt         <= burst_nxt;
            bus.host_rd_valid <= rd_grant;
            if (rd_grant)
                bus.host_rd_data <= bus.mem_rd_data;
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot_cnt;
        burst_nxt       = burst_cnt;
        rd_grant        = 1'b0;
        bus.core_ena    = 1'b0;
        bus.host_gnt    = 1'b0;
        bus.mem_addr    = bus.core_mem_addr;
        bus.mem_wr_data = bus.core_mem_wr_data;
        bus.mem_wr_ena  = 1'b0;

        case (state)
            S_CORE: begin
                bus.core_ena = bus.run;
                // a frozen core must not repeat a held write strobe
                bus.mem_wr_ena = bus.core_mem_wr_ena & bus.run;
                if (bus.run && slot_cnt != SLOT_MAX)
                    slot_nxt = slot_cnt + SW'(1);
                // the slot is satisfied by this cycle's enabled access, so handover follows it directly
                if (bus.host_req && slot_nxt == SLOT_MAX)
                    state_nxt = S_HANDOVER;
            end
            S_HANDOVER: begin
                burst_nxt = '0;
                state_nxt = S_HOST;
            end
            S_HOST: begin
                bus.mem_addr    = bus.host_addr;
                bus.mem_wr_data = bus.host_wr_data;
                bus.host_gnt    = bus.host_req;
                bus.mem_wr_ena  = bus.host_req & bus.host_wr_ena;
                rd_grant        = bus.host_req & ~bus.host_wr_ena;
                if (bus.host_req)
                    burst_nxt = burst_cnt + BW'(1);
                if (!bus.host_req || burst_nxt == BURST_MAX) begin
                    state_nxt = S_CORE;
                    slot_nxt  = '0;
                end
            end
            default: state_nxt = S_CORE;
        endcase

        if (rst) begin
            bus.core_ena   = 1'b0;
            bus.host_gnt   = 1'b0;
            bus.mem_wr_ena = 1'b0;
            rd_grant       = 1'b0;
        end
    end

`ifdef ARB_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (bus.run && state != S_CORE)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed testbench for rv32i_mem_arbiter: vector table plus hand sequences for burst limit, reset and run gating.
// Memory model is word-addressed on mem_addr[7:2], async read, sync write.
module tb_rv32i_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rv32i_mem_arbiter_if bus ();

`ifdef ARB_STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    rv32i_mem_arbiter #(.CORE_MIN_SLOT(4), .HOST_MAX_BURST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    logic [31:0] mem_arr [0:63];
    assign bus.mem_rd_data = mem_arr[bus.mem_addr[7:2]];
    always @(posedge clk)
        if (bus.mem_wr_ena)
            mem_arr[bus.mem_addr[7:2]] <= bus.mem_wr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        cwr;
        logic [31:0] caddr;
        logic [31:0] cdata;
        logic        req;
        logic        hwr;
        logic [31:0] haddr;
        logic [31:0] hdata;
        logic        e_ena;
        logic        e_gnt;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_rdv;
        logic [31:0] e_rdd;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic run, logic cwr, logic [31:0] caddr, logic [31:0] cdata,
                                logic req, logic hwr, logic [31:0] haddr, logic [31:0] hdata,
                                logic e_ena, logic e_gnt, logic e_wr, logic [31:0] e_addr,
                                logic [31:0] e_data, logic e_rdv, logic [31:0] e_rdd);
        vec_t v;
        v.run = run; v.cwr = cwr; v.caddr = caddr; v.cdata = cdata;
        v.req = req; v.hwr = hwr; v.haddr = haddr; v.hdata = hdata;
        v.e_ena = e_ena; v.e_gnt = e_gnt; v.e_wr = e_wr; v.e_addr = e_addr;
        v.e_data = e_data; v.e_rdv = e_rdv; v.e_rdd = e_rdd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic run, input logic cwr, input logic [31:0] caddr, input logic [31:0] cdata);
        bus.run              = run;
        bus.core_mem_wr_ena  = cwr;
        bus.core_mem_addr    = caddr;
        bus.core_mem_wr_data = cdata;
    endtask

    task automatic set_host(input logic req, input logic hwr, input logic [31:0] haddr, input logic [31:0] hdata);
        bus.host_req     = req;
        bus.host_wr_ena  = hwr;
        bus.host_addr    = haddr;
        bus.host_wr_data = hdata;
    endtask

    // Holds reset for two cycles with every request active, then leaves the bench at the start of cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        set_core(1'b1, 1'b1, 32'h100, 32'h1111_1111);
        set_host(1'b1, 1'b1, 32'h3C, 32'h2222_2222);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_gnt", {31'd0, bus.host_gnt}, 32'd0);
            chk("rst_ena", {31'd0, bus.core_ena}, 32'd0);
            chk("rst_wr",  {31'd0, bus.mem_wr_ena}, 32'd0);
            next_cycle();
        end
        rst = 1'b0;
        set_core(1'b1, 1'b0, 32'h100, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int          grants;
        logic        exp_ena, exp_gnt, prev_gnt;
        logic [31:0] saved;
        int          off;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        vecs[0] = mk(1, 0, 32'h100, 32'hC0DE0000, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h100, 32'h0,        0, 32'h0);
        vecs[1] = mk(1, 0, 32'h104, 32'hC0DE0001, 1, 1, 32'h40, 32'hDEADBEEF, 1, 0, 0, 32'h104, 32'h0,        0, 32'h0);
        vecs[2] = mk(1, 1, 32'h108, 32'hC0DE0002, 1, 1, 32'h40, 32'hDEADBEEF, 1, 0, 1, 32'h108, 32'hC0DE0002, 0, 32'h0);
        vecs[3] = mk(1, 0, 32'h10C, 32'hC0DE0003, 1, 1, 32'h40, 32'hDEADBEEF, 1, 0, 0, 32'h10C, 32'h0,        0, 32'h0);
        vecs[4] = mk(1, 1, 32'h110, 32'hC0DE0004, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 32'h110, 32'h0,        0, 32'h0);
        vecs[5] = mk(1, 1, 32'h110, 32'hC0DE0004, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40,  32'hDEADBEEF, 0, 32'h0);
        vecs[6] = mk(1, 1, 32'h110, 32'hC0DE0004, 1, 0, 32'h40, 32'h0,        0, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        vecs[7] = mk(1, 1, 32'h110, 32'hC0DE0004, 0, 0, 32'h80, 32'h0,        0, 0, 0, 32'h80,  32'h0,        1, 32'hDEADBEEF);
        vecs[8] = mk(1, 1, 32'h110, 32'hC0DE0008, 0, 0, 32'h80, 32'h0,        1, 0, 1, 32'h110, 32'hC0DE0008, 0, 32'h0);
        vecs[9] = mk(0, 1, 32'h114, 32'hC0DE0009, 1, 1, 32'h44, 32'h5555AAAA, 0, 0, 0, 32'h114, 32'h0,        0, 32'h0);

        // Preemption, host write then read, core resume, run gating
        do_reset();
        @(negedge clk);
        chk("rst_rdv",  {31'd0, bus.host_rd_valid}, 32'd0);
        chk("rst_rdd",  bus.host_rd_data, 32'd0);
        next_cycle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_core(vecs[i].run, vecs[i].cwr, vecs[i].caddr, vecs[i].cdata);
            set_host(vecs[i].req, vecs[i].hwr, vecs[i].haddr, vecs[i].hdata);
            @(negedge clk);
            chk($sformatf("v%0d_ena", i),  {31'd0, bus.core_ena},      {31'd0, vecs[i].e_ena});
            chk($sformatf("v%0d_gnt", i),  {31'd0, bus.host_gnt},      {31'd0, vecs[i].e_gnt});
            chk($sformatf("v%0d_wr", i),   {31'd0, bus.mem_wr_ena},    {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_addr", i), bus.mem_addr,               vecs[i].e_addr);
            chk($sformatf("v%0d_rdv", i),  {31'd0, bus.host_rd_valid}, {31'd0, vecs[i].e_rdv});
            if (vecs[i].e_wr)
                chk($sformatf("v%0d_wdata", i), bus.mem_wr_data, vecs[i].e_data);
            if (vecs[i].e_rdv)
                chk($sformatf("v%0d_rdd", i), bus.host_rd_data, vecs[i].e_rdd);
            next_cycle();
        end
        chk("mem_40", mem_arr[16], 32'hDEADBEEF);

        // Core only: memory follows the core, host never granted
        do_reset();
        for (int c = 0; c < 20; c++) begin
            set_core(1'b1, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            @(negedge clk);
            chk("co_ena",   {31'd0, bus.core_ena}, 32'd1);
            chk("co_gnt",   {31'd0, bus.host_gnt}, 32'd0);
            chk("co_addr",  bus.mem_addr, bus.core_mem_addr);
            chk("co_wdata", bus.mem_wr_data, bus.core_mem_wr_data);
            chk("co_wr",    {31'd0, bus.mem_wr_ena}, {31'd0, bus.core_mem_wr_ena});
            chk("co_rdata", bus.core_mem_rd_data, mem_arr[bus.core_mem_addr[7:2]]);
            next_cycle();
        end

        // Burst limit: 4 core, handover, 8 grants, repeating with period 13
        do_reset();
        grants   = 0;
        prev_gnt = 1'b0;
        for (int c = 0; c < 35; c++) begin
            set_core(1'b1, 1'b0, 32'h100 + 32'(c * 4), 32'h0);
            set_host(grants < 20, 1'b0, 32'h40, 32'h0);
            off     = c % 13;
            exp_ena = (off < 4);
            exp_gnt = (off >= 5);
            @(negedge clk);
            chk($sformatf("bl%0d_ena", c), {31'd0, bus.core_ena}, {31'd0, exp_ena});
            chk($sformatf("bl%0d_gnt", c), {31'd0, bus.host_gnt}, {31'd0, exp_gnt});
            chk($sformatf("bl%0d_rdv", c), {31'd0, bus.host_rd_valid}, {31'd0, prev_gnt});
            if (bus.host_gnt)
                grants++;
            prev_gnt = exp_gnt;
            next_cycle();
        end
        chk("bl_grants", 32'(grants), 32'd20);
        set_host(1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("bl_exit_ena", {31'd0, bus.core_ena}, 32'd0);
        chk("bl_exit_gnt", {31'd0, bus.host_gnt}, 32'd0);
        chk("bl_exit_rdd", bus.host_rd_data, 32'hDEADBEEF);
        next_cycle();
        @(negedge clk);
        chk("bl_back_ena", {31'd0, bus.core_ena}, 32'd1);
        next_cycle();

        // Reset during the third granted host write
        do_reset();
        saved  = mem_arr[10];
        grants = 0;
        for (int c = 0; c < 7; c++) begin
            set_host(1'b1, 1'b1, 32'h20 + 32'(grants * 4), 32'hA0000000 + 32'(grants));
            @(negedge clk);
            chk($sformatf("rm%0d_gnt", c), {31'd0, bus.host_gnt}, {31'd0, c >= 5});
            if (bus.host_gnt)
                grants++;
            next_cycle();
        end
        rst = 1'b1;
        set_host(1'b1, 1'b1, 32'h28, 32'hA0000002);
        @(negedge clk);
        chk("rm_rst_gnt", {31'd0, bus.host_gnt}, 32'd0);
        chk("rm_rst_wr",  {31'd0, bus.mem_wr_ena}, 32'd0);
        chk("rm_rst_ena", {31'd0, bus.core_ena}, 32'd0);
        next_cycle();
        rst = 1'b0;
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b0, 32'h130, 32'h0);
        @(negedge clk);
        chk("rm_ena",  {31'd0, bus.core_ena}, 32'd1);
        chk("rm_rdv",  {31'd0, bus.host_rd_valid}, 32'd0);
        chk("rm_addr", bus.mem_addr, 32'h130);
        chk("rm_mem9", mem_arr[9], 32'hA0000001);
        chk("rm_mem10", mem_arr[10], saved);
        next_cycle();

        // run low with slot_cnt = 2 holds off the host
        do_reset();
        for (int c = 0; c < 11; c++) begin
            set_core((c < 2) || (c > 5), 1'b0, 32'h100 + 32'(c * 4), 32'h0);
            set_host(c < 10, 1'b0, 32'h40, 32'h0);
            @(negedge clk);
            chk($sformatf("rn%0d_ena", c), {31'd0, bus.core_ena}, {31'd0, (c < 2) || (c == 6) || (c == 7)});
            chk($sformatf("rn%0d_gnt", c), {31'd0, bus.host_gnt}, {31'd0, c == 9});
`ifdef ARB_STALL_STATS_EN
            chk($sformatf("rn%0d_stall", c), stall_cycles, (c <= 8) ? 32'd0 : 32'(c - 8));
`endif
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
